// File: rtl/led_seq_pkg.sv
// Shared mode encodings and start patterns for the LED pattern sequencer.
package led_seq_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_COUNT = 2'd1;
  localparam logic [1:0] MODE_SCAN  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic [7:0] PAT_OFF   = 8'h00;
  localparam logic [7:0] PAT_SCAN  = 8'h01;
  localparam logic [7:0] PAT_BLINK = 8'hFF;

  function automatic logic [7:0] start_pattern(input logic [1:0] m);
    case (m)
      MODE_SCAN:  start_pattern = PAT_SCAN;
      MODE_BLINK: start_pattern = PAT_BLINK;
      default:    start_pattern = PAT_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// Valid/ready mode-command channel between host logic and the LED sequencer.
interface led_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_mode, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_mode, output cmd_ready);
endinterface

// File: rtl/led_sequencer_tick_prescaler.sv
// Wrap counter 0..TICK_DIV-1 producing a step strobe gated by pause.
module tick_prescaler #(
  parameter int TICK_DIV = 1048576
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic pause,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);
  assign tick      = w_at_last & ~pause;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (!pause) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// LED bank pattern controller: mode commands are held pending and applied on a step boundary.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 1048576,
  parameter int NLED     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  led_sequencer_if.slave    cmd,
  input  logic              pause,
  output logic [NLED-1:0]   leds,
  output logic [1:0]        mode,
  output logic              step_tick
);

  logic [7:0] r_leds;
  logic [1:0] r_mode;
  logic [1:0] r_pend_mode;
  logic       r_pending;
  logic [7:0] r_count;
  logic [2:0] r_pos;
  logic       r_dir_up;
  logic       r_phase;
  logic       w_tick;
  logic       w_accept;
  logic [2:0] w_pos_nxt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pause     (pause),
    .tick      (w_tick)
  );

  assign step_tick     = w_tick;
  assign cmd.cmd_ready = ~r_pending;
  assign w_accept      = cmd.cmd_valid & ~r_pending;
  assign leds          = r_leds;
  assign mode          = r_mode;

  // Scan bounces: each end position is shown once before the direction reverses.
  assign w_pos_nxt = r_dir_up ? r_pos + 3'd1 : r_pos - 3'd1;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_leds      <= PAT_OFF;
      r_mode      <= MODE_OFF;
      r_pend_mode <= MODE_OFF;
      r_pending   <= 1'b0;
      r_count     <= 8'h00;
      r_pos       <= 3'd0;
      r_dir_up    <= 1'b1;
      r_phase     <= 1'b0;
    end else begin
      if (w_tick && r_pending) begin
        r_mode    <= r_pend_mode;
        r_pending <= 1'b0;
        r_count   <= 8'h00;
        r_pos     <= 3'd0;
        r_dir_up  <= 1'b1;
        r_phase   <= 1'b0;
        r_leds    <= start_pattern(r_pend_mode);
      end else if (w_tick) begin
        case (r_mode)
          MODE_COUNT: begin
            r_count <= r_count + 8'd1;
            r_leds  <= r_count + 8'd1;
          end
          MODE_SCAN: begin
            r_pos  <= w_pos_nxt;
            r_leds <= 8'(1) << w_pos_nxt;
            if (w_pos_nxt == 3'd7)      r_dir_up <= 1'b0;
            else if (w_pos_nxt == 3'd0) r_dir_up <= 1'b1;
          end
          MODE_BLINK: begin
            r_phase <= ~r_phase;
            r_leds  <= r_phase ? PAT_BLINK : 8'h00;
          end
          default: r_leds <= PAT_OFF;
        endcase
      end
      // A command accepted on a tick edge waits for the next tick (pending was 0 above).
      if (w_accept) begin
        r_pend_mode <= cmd.cmd_mode;
        r_pending   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Randomized bench for led_sequencer against a step-index reference model.
module tb_led_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pause;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       step_tick;

  led_sequencer_if u_if ();

  led_sequencer #(.TICK_DIV(TD), .NLED(8)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cmd       (u_if.slave),
    .pause     (pause),
    .leds      (leds),
    .mode      (mode),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: displayed mode plus number of steps taken since that mode was applied.
  bit       m_known = 0;
  int       m_pc    = 0;
  int       m_mode  = 0;
  int       m_k     = 0;
  bit       m_pend  = 0;
  int       m_pmode = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_leds(input int m, input int k);
    int p;
    case (m)
      1: exp_leds = 8'(k % 256);
      2: begin
        p = k % 14;
        exp_leds = 8'(1) << ((p <= 7) ? p : 14 - p);
      end
      3: exp_leds = (k % 2 == 0) ? 8'hFF : 8'h00;
      default: exp_leds = 8'h00;
    endcase
  endfunction

  task automatic cycle(input bit r_n, input bit v, input int cm, input bit p);
    bit tick_e;
    bit ready_e;
    @(negedge clk);
    rst_n           = r_n;
    u_if.cmd_valid  = v;
    u_if.cmd_mode   = 2'(cm);
    pause           = p;
    #1;
    tick_e  = (m_pc == TD - 1) && !p;
    ready_e = !m_pend;
    if (m_known) begin
      check("leds", 32'(leds), 32'(exp_leds(m_mode, m_k)));
      check("mode", 32'(mode), 32'(m_mode));
      check("cmd_ready", 32'(u_if.cmd_ready), 32'(ready_e));
      check("step_tick", 32'(step_tick), 32'(tick_e));
    end
    if (!r_n) begin
      m_known = 1; m_pc = 0; m_mode = 0; m_k = 0; m_pend = 0; m_pmode = 0;
    end else begin
      if (tick_e && m_pend) begin
        m_mode = m_pmode; m_k = 0; m_pend = 0;
      end else if (tick_e) begin
        m_k++;
      end
      if (!p) m_pc = (m_pc + 1) % TD;
      if (v && ready_e) begin
        m_pmode = cm; m_pend = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 0);
  endtask

  task automatic wait_tick_cycle();
    for (int i = 0; i < TD && m_pc != TD - 1; i++) cycle(1, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; pause = 1'b0; u_if.cmd_valid = 1'b0; u_if.cmd_mode = 2'd0;
    cycle(0, 0, 0, 0);
    cycle(0, 1, 2, 1);
    idle(9);
    // COUNT for more than 256 steps to cover the 0xFF -> 0x00 wrap
    cycle(1, 1, 1, 0);
    idle(260 * TD + 6);
    // SCAN through several full bounces
    cycle(1, 1, 2, 0);
    idle(40 * TD);
    // BLINK, then a command accepted on the tick edge itself
    cycle(1, 1, 3, 0);
    idle(3 * TD + 1);
    wait_tick_cycle();
    cycle(1, 1, 2, 0);
    idle(3 * TD);
    // pending command held across a pause
    cycle(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1);
    idle(3 * TD);
    // reset mid-SCAN with a command pending
    cycle(1, 1, 2, 0);
    idle(5 * TD);
    wait_tick_cycle();
    cycle(1, 0, 0, 0);
    cycle(1, 1, 3, 0);
    cycle(0, 0, 0, 0);
    idle(3 * TD);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(299) != 0), ($urandom_range(7) == 0),
            int'($urandom_range(3)), ($urandom_range(5) == 0));
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Pattern controller for the 8-LED bank. It owns the LED register and sequences one of four display modes (off, binary count, bounce scan, blink) at a prescaled step rate. Mode changes arrive over a valid/ready command port and are applied only on a step boundary, so patterns never glitch mid-step. It sits between the board-level user_led0..7 pins and any host logic (buttons, UART, CSR) that selects the display.

Parameters:
TICK_DIV, 1048576, sys_clk cycles per pattern step; legal range >= 2; prescaler width is clog2(TICK_DIV).
NLED, 8, LED count; fixed at 8 for this revision, since COUNT mode uses 8 bits and SCAN positions run 0..7.

Ports:
sys_clk  in  1  system clock; all logic is on its rising edge.
sys_rst_n  in  1  reset, synchronous and active-low.
cmd_valid  in  1  host presents a mode command.
cmd_mode  in  2  requested mode: 0 OFF, 1 COUNT, 2 SCAN, 3 BLINK.
cmd_ready  out  1  block can accept a command.
pause  in  1  freezes the prescaler and therefore the pattern.
leds  out  8  LED drive; bit 7 maps to user_led0 and bit 0 to user_led7.
mode  out  2  mode currently displayed.
step_tick  out  1  one-cycle strobe on each pattern step.

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): prescaler=0, mode=OFF, leds=0x00, step counter=0, scan pos=0, scan dir=up, blink phase=0, pending=0. All inputs are ignored while in reset.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0. step_tick is combinational and equals (prescaler==TICK_DIV-1) & !pause. While pause=1 the prescaler holds its value and no tick occurs.
- cmd_ready = !pending, so it reads 1 during and after reset.
- Handshake: on an edge with cmd_valid & cmd_ready, the block latches pend_mode=cmd_mode and sets pending=1. cmd_ready is then low until the command is applied. cmd_mode is sampled only on the accepting edge.
- Apply: on an edge with step_tick & pending, the block:
  - sets mode=pend_mode and clears pending, so cmd_ready returns high the next cycle;
  - reinitialises pattern state to counter=0, pos=0, dir=up, phase=0;
  - loads leds with the mode's start pattern: OFF 0x00, COUNT 0x00, SCAN 0x01, BLINK 0xFF.
- Re-requesting the current mode is legal and restarts that mode's pattern.
- Advance: on an edge with step_tick & !pending:
  - OFF: leds=0x00.
  - COUNT: counter+1, modulo 256, with leds=new counter; 0xFF wraps to 0x00.
  - SCAN: leds=1<<pos. pos moves up 0..7; at 7 dir flips to down; at 0 dir flips to up. Sequence from start: 0x01,0x02,...,0x80,0x40,...,0x01,0x02. End positions are shown once, not repeated.
  - BLINK: phase toggles; leds=0xFF when phase=0 and 0x00 when phase=1, so leds alternate starting 0xFF.
- Latency: leds changes on the same edge that step_tick is high; step_tick never updates leds in any other cycle.
- Simultaneous accept and tick: if a command is accepted on an edge where step_tick=1, that tick advances the old mode using pending=0. The new command applies on the following tick.
- Pause with pending: the command waits; cmd_ready stays low until a tick occurs.
- Reset mid-operation: any pending command is discarded and state returns to the reset values on that edge.
- No other state changes occur between ticks.

Decomposition:
- Shared package led_seq_pkg:
  - mode encoding constants MODE_OFF/COUNT/SCAN/BLINK (2-bit);
  - start-pattern constants PAT_OFF=0x00, PAT_SCAN=0x01, PAT_BLINK=0xFF.
- One sub-module, tick_prescaler: parameter TICK_DIV; ports sys_clk, sys_rst_n, pause, tick. It holds the wrap counter and produces the gated strobe.
- The pattern FSMs (mode register, scan pos/dir, counter, phase) and the handshake stay in led_sequencer.

Test Plan:
1. Reset release with TICK_DIV=4, no command -> leds=0x00, mode=0, cmd_ready=1; step_tick strobes once every 4 cycles.
2. Command mode=1 accepted at cycle 1 -> cmd_ready=0 until the next tick. At that tick leds=0x00 and mode=1. Subsequent ticks give 0x01, 0x02, ...; after 256 steps leds wraps 0xFF->0x00.
3. Mode=2 -> leds steps through 0x01..0x80 then 0x40..0x01 then 0x02. Check 0x80 and 0x01 each appear for exactly one step at the turnarounds.
4. Command asserted on the same cycle as step_tick while in BLINK -> that tick toggles BLINK (0xFF->0x00); the new mode loads on the next tick.
5. pause=1 for 10 cycles with a pending command -> prescaler frozen, no step_tick, cmd_ready=0, leds unchanged. After pause=0 the command applies once the prescaler reaches 3.
6. sys_rst_n=0 for 1 cycle mid-SCAN with a command pending -> next cycle leds=0x00, mode=0, cmd_ready=1, prescaler=0; the pending command is not applied.
